// File: rtl/mac_seq_ctrl_pkg.sv
// Shared state encodings and length helpers for the MAC job sequencer.
// Pure declarations: no latency. No handshakes or backpressure.
package mac_seq_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_FETCH  = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  function automatic int unsigned clip_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_lane_mask.sv
// Remaining element count -> per-lane enable (lane j live while j < rem).
// Combinational, zero latency. No backpressure.
module mac_seq_ctrl_lane_mask #(
  parameter int PARALLEL = 1,
  parameter int LENW     = 6
) (
  input  logic [LENW-1:0]     rem,
  output logic [PARALLEL-1:0] lane_en
);

  always_comb begin
    lane_en = '0;
    for (int j = 0; j < PARALLEL; j++) begin
      lane_en[j] = (rem > LENW'(j));
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer: accepts (base,len) jobs, streams masked operand beats to the MAC, returns the accumulator.
// Latency: accept cycle t0 -> res_valid in t0+ceil(Lc/PARALLEL)+3+PIPE_LAT; one job in flight at a time.
// Backpressure: job_ready only in IDLE; result held until res_ready. Optional abort input under MAC_SEQ_ABORT_EN.
module mac_seq_ctrl #(
  parameter int PARALLEL = 1,
  parameter int DW       = 8,
  parameter int ACCW     = 16,
  parameter int ADDRW    = 5,
  parameter int MAX_LEN  = 25,
  parameter int PIPE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [ADDRW-1:0]       job_base,
  input  logic [ADDRW:0]         job_len,
`ifdef MAC_SEQ_ABORT_EN
  input  logic                   abort,
`endif
  output logic                   mem_rd_en,
  output logic [ADDRW-1:0]       mem_addr,
  input  logic [PARALLEL*DW-1:0] mem_a_rdata,
  input  logic [PARALLEL*DW-1:0] mem_b_rdata,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic [PARALLEL*DW-1:0] mac_a,
  output logic [PARALLEL*DW-1:0] mac_b,
  input  logic [ACCW-1:0]        mac_acc,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACCW-1:0]        res_data,
  output logic                   busy
);
  import mac_seq_ctrl_pkg::*;

  localparam int LENW = ADDRW + 1;
  localparam int DRW  = cnt_width(PIPE_LAT);
  localparam logic [ADDRW-1:0] ADDR_STEP = ADDRW'(PARALLEL);
  localparam logic [LENW-1:0]  REM_STEP  = LENW'(PARALLEL);

  logic [2:0]          state_q, state_d;
  logic [ADDRW-1:0]    addr_q;
  logic [LENW-1:0]     rem_q;
  logic [LENW-1:0]     len_clip;
  logic [DRW-1:0]      drain_q;
  logic                en_q;
  logic [PARALLEL-1:0] mask_q;
  logic [PARALLEL-1:0] lane_en;
  logic [ACCW-1:0]     res_q;
  logic                accept;
  logic                last_beat;
  logic                drain_done;
  logic                fetch_beat;
  logic                abort_hit;

  assign len_clip   = LENW'(clip_len(32'(job_len), MAX_LEN));
  assign accept     = job_valid && (state_q == ST_IDLE);
  assign last_beat  = (rem_q <= REM_STEP);
  assign drain_done = (drain_q == DRW'(PIPE_LAT));

`ifdef MAC_SEQ_ABORT_EN
  logic abort_clr_q;

  assign abort_hit = abort && ((state_q == ST_CLEAR) || (state_q == ST_FETCH) ||
                               (state_q == ST_DRAIN));

  // Aborted jobs leave partial sums behind; wipe them in the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      abort_clr_q <= 1'b0;
    end else begin
      abort_clr_q <= abort_hit;
    end
  end

  assign mac_clr = (state_q == ST_CLEAR) || abort_clr_q;
`else
  assign abort_hit = 1'b0;
  assign mac_clr   = (state_q == ST_CLEAR);
`endif

  assign fetch_beat = (state_q == ST_FETCH) && !abort_hit;

  mac_seq_ctrl_lane_mask #(
    .PARALLEL(PARALLEL),
    .LENW    (LENW)
  ) u_lane_mask (
    .rem    (rem_q),
    .lane_en(lane_en)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (job_valid) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = (rem_q == '0) ? ST_DRAIN : ST_FETCH;
      ST_FETCH:  if (last_beat) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_done) state_d = ST_RESULT;
      ST_RESULT: if (res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      drain_q <= '0;
      en_q    <= 1'b0;
      mask_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= job_base;
        rem_q  <= len_clip;
      end else if (state_q == ST_FETCH) begin
        addr_q <= addr_q + ADDR_STEP;
        rem_q  <= last_beat ? '0 : rem_q - REM_STEP;
      end
      drain_q <= ((state_q == ST_DRAIN) && !drain_done) ? drain_q + DRW'(1) : '0;
      // SRAM data lands one cycle after the strobe, so lane valids ride one stage behind.
      en_q    <= fetch_beat;
      mask_q  <= fetch_beat ? lane_en : '0;
      if ((state_q == ST_DRAIN) && (state_d == ST_RESULT)) begin
        res_q <= mac_acc;
      end
    end
  end

  for (genvar j = 0; j < PARALLEL; j++) begin : g_lane
    assign mac_a[j*DW +: DW] = (en_q && mask_q[j]) ? mem_a_rdata[j*DW +: DW] : '0;
    assign mac_b[j*DW +: DW] = (en_q && mask_q[j]) ? mem_b_rdata[j*DW +: DW] : '0;
  end

  assign job_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign mem_rd_en = (state_q == ST_FETCH);
  assign mem_addr  = addr_q;
  assign mac_en    = en_q;
  assign res_valid = (state_q == ST_RESULT);
  assign res_data  = res_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench: two sequencers (PARALLEL=1 and 4) share jobs, SRAM and datapath stubs; a timeline model predicts every output.
module tb_mac_seq_ctrl;
  localparam int NI       = 2;
  localparam int PIPE_LAT = 1;
  localparam int MAX_LEN  = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b, job_valid, res_ready;
  logic [4:0] job_base;
  logic [5:0] job_len;
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];

  logic        job_ready0, mem_rd_en0, mac_clr0, mac_en0, res_valid0, busy0;
  logic        job_ready1, mem_rd_en1, mac_clr1, mac_en1, res_valid1, busy1;
  logic [4:0]  mem_addr0, mem_addr1;
  logic [7:0]  mac_a0, mac_b0;
  logic [31:0] mac_a1, mac_b1;
  logic [15:0] res_data0, res_data1;

  logic [31:0] ra [NI];
  logic [31:0] rb [NI];
  logic [15:0] acc [NI];

  mac_seq_ctrl u_dut0 (
    .clk(clk), .rst_b(rst_b), .job_valid(job_valid), .job_ready(job_ready0),
    .job_base(job_base), .job_len(job_len),
`ifdef MAC_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0),
    .mem_a_rdata(ra[0][7:0]), .mem_b_rdata(rb[0][7:0]),
    .mac_clr(mac_clr0), .mac_en(mac_en0), .mac_a(mac_a0), .mac_b(mac_b0),
    .mac_acc(acc[0]), .res_valid(res_valid0), .res_ready(res_ready),
    .res_data(res_data0), .busy(busy0)
  );

  mac_seq_ctrl #(.PARALLEL(4)) u_dut1 (
    .clk(clk), .rst_b(rst_b), .job_valid(job_valid), .job_ready(job_ready1),
    .job_base(job_base), .job_len(job_len),
`ifdef MAC_SEQ_ABORT_EN
    .abort(1'b0),
`endif
    .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1),
    .mem_a_rdata(ra[1]), .mem_b_rdata(rb[1]),
    .mac_clr(mac_clr1), .mac_en(mac_en1), .mac_a(mac_a1), .mac_b(mac_b1),
    .mac_acc(acc[1]), .res_valid(res_valid1), .res_ready(res_ready),
    .res_data(res_data1), .busy(busy1)
  );

  logic        rd_w [NI], clr_w [NI], en_w [NI], rv_w [NI], jr_w [NI], busy_w [NI];
  logic [4:0]  addr_w [NI];
  logic [31:0] ma_w [NI], mb_w [NI];
  logic [15:0] rdat_w [NI];

  assign rd_w[0] = mem_rd_en0;  assign rd_w[1] = mem_rd_en1;
  assign clr_w[0] = mac_clr0;   assign clr_w[1] = mac_clr1;
  assign en_w[0] = mac_en0;     assign en_w[1] = mac_en1;
  assign rv_w[0] = res_valid0;  assign rv_w[1] = res_valid1;
  assign jr_w[0] = job_ready0;  assign jr_w[1] = job_ready1;
  assign busy_w[0] = busy0;     assign busy_w[1] = busy1;
  assign addr_w[0] = mem_addr0; assign addr_w[1] = mem_addr1;
  assign ma_w[0] = {24'b0, mac_a0}; assign ma_w[1] = mac_a1;
  assign mb_w[0] = {24'b0, mac_b0}; assign mb_w[1] = mac_b1;
  assign rdat_w[0] = res_data0; assign rdat_w[1] = res_data1;

  function automatic logic [15:0] dot4(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] s;
    s = '0;
    for (int j = 0; j < 4; j++) s = s + 16'(a[8*j +: 8]) * 16'(b[8*j +: 8]);
    return s;
  endfunction

  // SRAM with one-cycle read latency and a PIPE_LAT=1 accumulating datapath, per instance.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NI; i++) begin
        ra[i] <= '0; rb[i] <= '0; acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (rd_w[i]) begin
          for (int j = 0; j < 4; j++) begin
            ra[i][8*j +: 8] <= mem_a[(int'(addr_w[i]) + j) % 32];
            rb[i][8*j +: 8] <= mem_b[(int'(addr_w[i]) + j) % 32];
          end
        end
        if (clr_w[i]) acc[i] <= '0;
        else if (en_w[i]) acc[i] <= acc[i] + dot4(ma_w[i], mb_w[i]);
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit act [NI];
  int t0 [NI], nb [NI], lcm [NI], bm [NI];
  logic [15:0] er [NI];
  int lat [NI], en_cnt [NI], rd_cnt [NI];
  logic [15:0] got [NI];
  int addr_log [$];

  function automatic int par(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [15:0] exp_sum(input int b, input int lc);
    int s;
    s = 0;
    for (int e = 0; e < lc; e++) s += int'(mem_a[(b + e) % 32]) * int'(mem_b[(b + e) % 32]);
    return 16'(s);
  endfunction

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got_v, exp_v);
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < NI; i++) begin
      int d;
      bit busy_e, rd_e, en_e, rv_e;
      logic [31:0] a_e, b_e;
      string pre;
      pre    = $sformatf("u%0d@%0d ", i, cyc);
      d      = act[i] ? cyc - t0[i] : -1;
      busy_e = act[i] && d >= 1;
      rd_e   = act[i] && d >= 2 && d <= nb[i] + 1;
      en_e   = act[i] && d >= 3 && d <= nb[i] + 2;
      rv_e   = act[i] && d >= nb[i] + 3 + PIPE_LAT;
      a_e = '0; b_e = '0;
      if (en_e) begin
        for (int j = 0; j < par(i); j++) begin
          int e;
          e = (d - 3) * par(i) + j;
          if (e < lcm[i]) begin
            a_e[8*j +: 8] = mem_a[(bm[i] + e) % 32];
            b_e[8*j +: 8] = mem_b[(bm[i] + e) % 32];
          end
        end
      end
      chk({pre, "busy"}, 32'(busy_w[i]), 32'(busy_e));
      chk({pre, "job_ready"}, 32'(jr_w[i]), 32'(!busy_e));
      chk({pre, "mac_clr"}, 32'(clr_w[i]), 32'(act[i] && d == 1));
      chk({pre, "mem_rd_en"}, 32'(rd_w[i]), 32'(rd_e));
      if (rd_e) chk({pre, "mem_addr"}, 32'(addr_w[i]), 32'((bm[i] + (d - 2) * par(i)) % 32));
      chk({pre, "mac_en"}, 32'(en_w[i]), 32'(en_e));
      chk({pre, "mac_a"}, ma_w[i], a_e);
      chk({pre, "mac_b"}, mb_w[i], b_e);
      chk({pre, "res_valid"}, 32'(rv_w[i]), 32'(rv_e));
      if (rv_e) chk({pre, "res_data"}, 32'(rdat_w[i]), 32'(er[i]));
      if (act[i]) begin
        if (rd_w[i]) begin
          rd_cnt[i]++;
          if (i == 0) addr_log.push_back(int'(addr_w[i]));
        end
        if (en_w[i]) en_cnt[i]++;
        if (rv_w[i] && lat[i] < 0) lat[i] = d;
      end
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      if (!act[i] && job_valid) begin
        act[i]    = 1'b1;
        t0[i]     = cyc;
        lcm[i]    = (int'(job_len) > MAX_LEN) ? MAX_LEN : int'(job_len);
        nb[i]     = (lcm[i] + par(i) - 1) / par(i);
        bm[i]     = int'(job_base);
        er[i]     = exp_sum(bm[i], lcm[i]);
        lat[i]    = -1;
        en_cnt[i] = 0;
        rd_cnt[i] = 0;
        if (i == 0) addr_log.delete();
      end else if (act[i] && (cyc - t0[i]) >= nb[i] + 3 + PIPE_LAT && res_ready) begin
        act[i] = 1'b0;
        got[i] = rdat_w[i];
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    job_valid = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < NI; i++) act[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic run_job(input int base, input int len, input int hold);
    int w;
    int h;
    h = hold;
    job_base  = 5'(base);
    job_len   = 6'(len);
    job_valid = 1'b1;
    res_ready = 1'b0;
    tick();
    job_valid = 1'b0;
    w = 0;
    while ((act[0] || act[1]) && w < 300) begin
      if ((res_valid0 || res_valid1) && h > 0) h--;
      res_ready = (h > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
      w++;
    end
    res_ready = 1'b0;
    chk("job_timeout", 32'(w >= 300), 32'd0);
    if (w >= 300) do_reset();
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 32; k++) begin
      mem_a[k] = 8'(k + 1);
      mem_b[k] = 8'd1;
    end
  endtask

  initial begin
    rst_b = 1'b0; job_valid = 1'b0; res_ready = 1'b0; job_base = '0; job_len = '0;
    for (int k = 0; k < 32; k++) begin mem_a[k] = '0; mem_b[k] = '0; end
    #1;
    chk("reset job_ready", 32'(job_ready0), 32'd1);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset mem_rd_en", 32'(mem_rd_en1), 32'd0);
    chk("reset res_valid", 32'(res_valid1), 32'd0);
    chk("reset res_data", 32'(res_data0), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    // Ramp data: sum 1..25 = 325; latency 25+4 at P=1, 7+4 at P=4.
    fill_ramp();
    run_job(0, 25, 0);
    chk("ramp latency p1", 32'(lat[0]), 32'd29);
    chk("ramp latency p4", 32'(lat[1]), 32'd11);
    chk("ramp result p1", 32'(got[0]), 32'h0145);
    chk("ramp result p4", 32'(got[1]), 32'h0145);

    for (int k = 0; k < 32; k++) begin mem_a[k] = 8'd2; mem_b[k] = 8'd2; end
    run_job(0, 7, 0);
    chk("len7 result p4", 32'(got[1]), 32'h001C);
    chk("len7 mac_en beats p4", 32'(en_cnt[1]), 32'd2);
    chk("len7 result p1", 32'(got[0]), 32'h001C);
    chk("len7 mac_en beats p1", 32'(en_cnt[0]), 32'd7);

    run_job(5, 0, 0);
    chk("len0 reads p1", 32'(rd_cnt[0]), 32'd0);
    chk("len0 reads p4", 32'(rd_cnt[1]), 32'd0);
    chk("len0 result p1", 32'(got[0]), 32'd0);
    chk("len0 result p4", 32'(got[1]), 32'd0);

    run_job(30, 4, 0);
    chk("wrap read count", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      chk("wrap addr0", 32'(addr_log[0]), 32'd30);
      chk("wrap addr1", 32'(addr_log[1]), 32'd31);
      chk("wrap addr2", 32'(addr_log[2]), 32'd0);
      chk("wrap addr3", 32'(addr_log[3]), 32'd1);
    end

    // Held result: elements 4..13 sum to 85.
    fill_ramp();
    run_job(3, 10, 12);
    chk("held result p1", 32'(got[0]), 32'h0055);
    chk("held result p4", 32'(got[1]), 32'h0055);

    // Async reset while fetching, then a clean job.
    job_base = '0; job_len = 6'd25; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    repeat (5) tick();
    rst_b = 1'b0;
    for (int i = 0; i < NI; i++) act[i] = 1'b0;
    #1;
    chk("midrst job_ready", 32'(job_ready0), 32'd1);
    chk("midrst busy", 32'(busy0), 32'd0);
    chk("midrst mem_rd_en", 32'(mem_rd_en0), 32'd0);
    chk("midrst mac_en", 32'(mac_en1), 32'd0);
    chk("midrst mac_clr", 32'(mac_clr0), 32'd0);
    chk("midrst res_valid", 32'(res_valid0), 32'd0);
    chk("midrst mem_addr", 32'(mem_addr0), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    run_job(0, 25, 0);
    chk("post-reset result p1", 32'(got[0]), 32'h0145);
    chk("post-reset result p4", 32'(got[1]), 32'h0145);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 32; k++) begin
        mem_a[k] = 8'($urandom_range(0, 255));
        mem_b[k] = 8'($urandom_range(0, 255));
      end
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(0, 32)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
